bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_WAIT, 4, consecutive cycles a pending DMA request may lose before it is forced a slot (range 1..15).
REQ-002 Parameter DM_TOP, 32'h0000_2FFF, highest byte address served by the data memory.
REQ-003 Clock and reset: one clock, `clk`; synchronous active-high reset, `reset`.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cpu_req  in  1  M-stage load/store valid.
REQ-007 cpu_exc  in  1  M-stage access already flagged AdEL/AdES.
REQ-008 cpu_we  in  1  store.
REQ-009 cpu_addr  in  32  byte address.
REQ-010 cpu_wdata  in  32  store data, already lane-aligned.
REQ-011 cpu_byteen  in  4  store byte enables.
REQ-012 cpu_stall  out  1  M-stage must hold this cycle.
REQ-013 cpu_rvalid  out  1  registered; cpu_rdata valid.
REQ-014 cpu_rdata  out  32  raw word, before sub-word extraction.
REQ-015 dma_req, dma_we  in  1 each  DMA request, write.
REQ-016 dma_addr, dma_wdata  in  32 each  word address/data.
REQ-017 dma_gnt  out  1  DMA access issued this cycle.
REQ-018 dma_rvalid  out  1; dma_rdata  out  32  DMA read return.
REQ-019 dm_we  out  1; dm_addr  out  32; dm_wdata  out  32; dm_byteen  out  4  memory port.
REQ-020 dm_rdata  in  32  memory read data, one cycle after address.

Function
REQ-021 cpu_hit = cpu_req & ~cpu_exc & (cpu_addr <= DM_TOP); non-hit CPU accesses never touch the memory port and never stall.
REQ-022 At most one access issued per cycle; issue decision combinational in the same cycle.
REQ-023 Priority: forced DMA (dma_req & age == MAX_WAIT) > cpu_hit > dma_req.
REQ-024 cpu_stall = cpu_hit & DMA issued this cycle; otherwise 0.
REQ-025 age: 4-bit counter; +1 when dma_req & ~dma_gnt, saturating at MAX_WAIT; cleared when dma_gnt or ~dma_req.
REQ-026 After a forced DMA slot the age is 0, so a stalled CPU wins the next cycle; CPU stall never exceeds 1 consecutive cycle.
REQ-027 Idle port: dm_we=0, dm_byteen=4'b0000, dm_addr=0, dm_wdata=0.
REQ-028 CPU issue: dm_addr=cpu_addr, dm_we=cpu_we, dm_byteen = cpu_we ? cpu_byteen : 4'b0000.
REQ-029 DMA issue: dm_addr=dma_addr with bits[1:0] forced 0, dm_byteen = dma_we ? 4'b1111 : 4'b0000.
REQ-030 Return owner register, states NONE/CPU/DMA: next = CPU on CPU read issue, DMA on DMA read issue, else NONE.
REQ-031 cpu_rvalid = (owner==CPU), dma_rvalid = (owner==DMA); both rdata outputs are driven from dm_rdata and are 0 when not valid.
REQ-032 Writes produce no rvalid; the latency from read issue to rvalid is exactly 1 cycle.
REQ-033 cpu_exc asserted: access suppressed, no write reaches memory, and no stall is raised.

Reset
REQ-034 On reset: age=0, owner=NONE, cpu_rvalid=dma_rvalid=0, rdata outputs 0; combinational outputs follow REQ-027 only if no request is present.
REQ-035 Reset mid-read: the pending return is dropped and no rvalid is produced in the following cycle.

Structure
REQ-036 Shared package/header: owner state encodings, DM_TOP, default MAX_WAIT.
REQ-037 One sub-module, arb_age_counter (saturating counter with clear); the rest is flat.

Verification
REQ-038 CPU load 0x0000_0010, no DMA -> dm_addr=0x10, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=dm_rdata.
REQ-039 Both requests continuously with MAX_WAIT=4 -> CPU wins 4 cycles, DMA gnt on the 5th with cpu_stall=1, then CPU wins; pattern repeats.
REQ-040 CPU store to 0x0000_7F00 with DMA write pending -> dma_gnt=1 same cycle, cpu_stall=0, and the CPU store never reaches the memory port.
REQ-041 cpu_exc=1 with cpu_we=1, addr 0x4 -> dm_we=0, cpu_stall=0.
REQ-042 DMA read 0x0000_0103 -> dm_addr=0x100, dma_rvalid next cycle; reset in the issue cycle -> dma_rvalid=0 afterwards.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: return-owner encodings and
// default parameter values.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [31:0] DM_TOP_DEFAULT   = 32'h0000_2FFF;
    localparam int unsigned MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating up-counter with synchronous clear; tracks how long a pending DMA
// request has been losing arbitration.
module arb_age_counter #(
    parameter logic [3:0] MAX_COUNT = 4'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 4'd0;
        end else if (inc && (count_q < MAX_COUNT)) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bus_arbiter.sv
// Single-port data-memory arbiter between the CPU M-stage and a DMA engine,
// with age-based anti-starvation for DMA and a one-cycle read return path.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter logic [31:0] DM_TOP   = DM_TOP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_exc,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata
);

    localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

    logic       cpu_hit;
    logic       dma_forced;
    logic       dma_issue;
    logic       cpu_issue;
    logic [3:0] age;
    owner_e     owner_q;
    owner_e     owner_d;

    // Issue decision: a starved DMA beats the CPU, otherwise the CPU beats DMA.
    always_comb begin
        cpu_hit    = cpu_req & ~cpu_exc & (cpu_addr <= DM_TOP);
        dma_forced = dma_req & (age == AGE_MAX);
        dma_issue  = dma_forced | (dma_req & ~cpu_hit);
        cpu_issue  = cpu_hit & ~dma_issue;
        dma_gnt    = dma_issue;
        cpu_stall  = cpu_hit & dma_issue;
    end

    arb_age_counter #(
        .MAX_COUNT (AGE_MAX)
    ) u_age (
        .clk   (clk),
        .reset (reset),
        .inc   (dma_req & ~dma_issue),
        .clr   (~dma_req | dma_issue),
        .count (age)
    );

    // Memory port mux; DMA addresses are word-aligned and writes are full words.
    always_comb begin
        dm_we     = 1'b0;
        dm_addr   = 32'h0000_0000;
        dm_wdata  = 32'h0000_0000;
        dm_byteen = 4'b0000;
        if (dma_issue) begin
            dm_we     = dma_we;
            dm_addr   = dma_addr & 32'hFFFF_FFFC;
            dm_wdata  = dma_wdata;
            dm_byteen = dma_we ? 4'b1111 : 4'b0000;
        end else if (cpu_issue) begin
            dm_we     = cpu_we;
            dm_addr   = cpu_addr;
            dm_wdata  = cpu_wdata;
            dm_byteen = cpu_we ? cpu_byteen : 4'b0000;
        end else begin
            dm_we     = 1'b0;
        end
    end

    // Remember who owns the read data arriving next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (dma_issue && !dma_we) begin
            owner_d = OWN_DMA;
        end else if (cpu_issue && !cpu_we) begin
            owner_d = OWN_CPU;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Return-owner register; reset drops any return in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Steer returning memory data to its owner; zero when not valid.
    always_comb begin
        cpu_rvalid = 1'b0;
        dma_rvalid = 1'b0;
        case (owner_q)
            OWN_CPU: cpu_rvalid = 1'b1;
            OWN_DMA: dma_rvalid = 1'b1;
            default: begin
                cpu_rvalid = 1'b0;
                dma_rvalid = 1'b0;
            end
        endcase
        cpu_rdata = cpu_rvalid ? dm_rdata : 32'h0000_0000;
        dma_rdata = dma_rvalid ? dm_rdata : 32'h0000_0000;
    end

endmodule
